// File: rtl/add_issue_sequencer.sv
// ----------------------------------------------------------------------------
// add_issue_sequencer
//
// Sits directly upstream of a multi-cycle adder. Operand pairs are buffered in
// a small FIFO and issued one at a time. For each pair the sequencer:
//   1. drives the operands with AddGo low for one cycle so the adder can load,
//   2. holds AddGo high for ADD_LATENCY cycles,
//   3. captures AddSum/AddCout and holds them on a valid/ready result port.
//
// Optional feature (compile-time macro):
//   ADD_ISSUE_SELFCHECK_EN - when defined, each captured result is compared
//                            against AddA+AddB. Any miscompare sets the sticky
//                            Mismatch flag, which only Reset clears. When it is
//                            not defined, Mismatch is tied low and no compare
//                            logic is built.
//
// Parameters:
//   WIDTH        operand width; must match the adder
//   DEPTH        operand FIFO entries (power of 2, >= 2)
//   ADD_LATENCY  cycles AddGo is held high before the result is sampled (>= 1)
//
// Ports:
//   Clock     in   single clock, rising edge
//   Reset     in   synchronous, active-high
//   InValid   in   operand pair offered
//   InReady   out  FIFO can accept (Count < DEPTH)
//   InA/InB   in   operands
//   AddA/AddB out  operands to the adder (change only on issue)
//   AddGo     out  adder run strobe (low = load, high = run)
//   AddSum    in   adder sum
//   AddCout   in   adder carry-out
//   ResValid  out  result held valid
//   ResReady  in   downstream accepts the result
//   ResSum    out  captured sum
//   ResCout   out  captured carry
//   Count     out  FIFO occupancy
//   Mismatch  out  sticky self-check error flag
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | AddGo low; pops the FIFO head into AddA/AddB when Count != 0
// LOAD  | one cycle with AddGo low and operands stable (adder loads)
// RUN   | AddGo high for ADD_LATENCY cycles; captures result on last one
// DONE  | AddGo low; result held until ResReady
// ----------------------------------------------------------------------------
module add_issue_sequencer #(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 4,
    parameter int ADD_LATENCY = 5
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [WIDTH-1:0]         InA,
    input  logic [WIDTH-1:0]         InB,
    output logic [WIDTH-1:0]         AddA,
    output logic [WIDTH-1:0]         AddB,
    output logic                     AddGo,
    input  logic [WIDTH-1:0]         AddSum,
    input  logic                     AddCout,
    output logic                     ResValid,
    input  logic                     ResReady,
    output logic [WIDTH-1:0]         ResSum,
    output logic                     ResCout,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Mismatch
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(ADD_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [LAT_W-1:0]   run_cnt_q;

    // ------------------------------------------------------------------------
    // Operand FIFO. Entries hold {A, B}. Pointers are PTR_W bits wide, so they
    // wrap modulo DEPTH on their own.
    // ------------------------------------------------------------------------
    logic [2*WIDTH-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push;
    logic               pop;
    logic [2*WIDTH-1:0] head;

    // InReady depends only on the registered count, so a pop in the same
    // cycle never lets a push into a full FIFO.
    assign InReady = (count_q != FULL_COUNT);
    assign Count   = count_q;
    assign push    = InValid && InReady;
    assign pop     = (state_q == S_IDLE) && (count_q != '0);
    assign head    = fifo_mem[rd_ptr_q];

    always_ff @(posedge Clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {InA, InB};
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Self-check: expected result computed one bit wider so the carry is
    // compared as well.
    // ------------------------------------------------------------------------
`ifdef ADD_ISSUE_SELFCHECK_EN
    logic [WIDTH:0] expected_sum;
    logic           result_bad;

    assign expected_sum = {1'b0, AddA} + {1'b0, AddB};
    assign result_bad   = ({AddCout, AddSum} != expected_sum);
`endif

    // ------------------------------------------------------------------------
    // Sequencing FSM. All adder-facing and result outputs are registered here.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            run_cnt_q <= '0;
            AddA      <= '0;
            AddB      <= '0;
            AddGo     <= 1'b0;
            ResValid  <= 1'b0;
            ResSum    <= '0;
            ResCout   <= 1'b0;
            Mismatch  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    AddGo <= 1'b0;
                    if (pop) begin
                        AddA    <= head[2*WIDTH-1:WIDTH];
                        AddB    <= head[WIDTH-1:0];
                        state_q <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    AddGo     <= 1'b1;
                    run_cnt_q <= '0;
                    state_q   <= S_RUN;
                end

                S_RUN: begin
                    if (run_cnt_q == LAT_LAST) begin
                        ResSum   <= AddSum;
                        ResCout  <= AddCout;
                        ResValid <= 1'b1;
                        AddGo    <= 1'b0;
                        state_q  <= S_DONE;
`ifdef ADD_ISSUE_SELFCHECK_EN
                        if (result_bad) begin
                            Mismatch <= 1'b1;
                        end
`endif
                    end else begin
                        AddGo     <= 1'b1;
                        run_cnt_q <= run_cnt_q + 1'b1;
                    end
                end

                S_DONE: begin
                    AddGo <= 1'b0;
                    if (ResValid && ResReady) begin
                        ResValid <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end

                default: begin
                    AddGo    <= 1'b0;
                    ResValid <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_issue_sequencer.sv
// ----------------------------------------------------------------------------
// tb_add_issue_sequencer
//
// Directed bench for add_issue_sequencer with an ideal combinational adder
// model driving AddSum/AddCout. The model can be forced to return a wrong sum
// to exercise the optional self-check (ADD_ISSUE_SELFCHECK_EN).
// ----------------------------------------------------------------------------
module tb_add_issue_sequencer;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int LAT   = 5;

`ifdef ADD_ISSUE_SELFCHECK_EN
    localparam logic MISMATCH_ON_BAD = 1'b1;
`else
    localparam logic MISMATCH_ON_BAD = 1'b0;
`endif

    logic                   Clock = 1'b0;
    logic                   Reset;
    logic                   InValid;
    logic                   InReady;
    logic [WIDTH-1:0]       InA;
    logic [WIDTH-1:0]       InB;
    logic [WIDTH-1:0]       AddA;
    logic [WIDTH-1:0]       AddB;
    logic                   AddGo;
    logic [WIDTH-1:0]       AddSum;
    logic                   AddCout;
    logic                   ResValid;
    logic                   ResReady;
    logic [WIDTH-1:0]       ResSum;
    logic                   ResCout;
    logic [$clog2(DEPTH):0] Count;
    logic                   Mismatch;

    logic           bad;
    logic [WIDTH:0] model_sum;

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    assign model_sum = {1'b0, AddA} + {1'b0, AddB};
    assign AddSum    = bad ? '0   : model_sum[WIDTH-1:0];
    assign AddCout   = bad ? 1'b0 : model_sum[WIDTH];

    add_issue_sequencer #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .ADD_LATENCY (LAT)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .InA      (InA),
        .InB      (InB),
        .AddA     (AddA),
        .AddB     (AddB),
        .AddGo    (AddGo),
        .AddSum   (AddSum),
        .AddCout  (AddCout),
        .ResValid (ResValid),
        .ResReady (ResReady),
        .ResSum   (ResSum),
        .ResCout  (ResCout),
        .Count    (Count),
        .Mismatch (Mismatch)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        InValid = 1'b1;
        InA     = a;
        InB     = b;
        tick();
        InValid = 1'b0;
    endtask

    // Advances at least one cycle, then until ResValid or the budget expires.
    task automatic wait_valid(input string tag, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ResValid && n < 40);
        check({tag, "_valid"}, ResValid, 1'b1);
    endtask

    task automatic expect_res(input string tag, input logic [WIDTH-1:0] s, input logic c);
        int n;
        wait_valid(tag, n);
        check({tag, "_sum"},  ResSum,  s);
        check({tag, "_cout"}, ResCout, c);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic seen;

        Reset    = 1'b1;
        InValid  = 1'b0;
        InA      = '0;
        InB      = '0;
        ResReady = 1'b0;
        bad      = 1'b0;
        repeat (3) tick();
        Reset = 1'b0;

        // Reset state
        check("rst_count",    Count,    0);
        check("rst_inready",  InReady,  1);
        check("rst_addgo",    AddGo,    0);
        check("rst_adda",     AddA,     0);
        check("rst_addb",     AddB,     0);
        check("rst_resvalid", ResValid, 0);
        check("rst_ressum",   ResSum,   0);
        check("rst_rescout",  ResCout,  0);
        check("rst_mismatch", Mismatch, 0);

        // F + F, latency from pop to ResValid
        ResReady = 1'b1;
        push(4'hF, 4'hF);
        check("ff_count_push", Count, 1);
        tick();
        check("ff_count_pop", Count, 0);
        check("ff_adda",      AddA,  4'hF);
        check("ff_addb",      AddB,  4'hF);
        check("ff_load_go",   AddGo, 0);
        wait_valid("ff", n);
        check("ff_latency", n, LAT + 1);
        check("ff_sum",     ResSum,  4'hE);
        check("ff_cout",    ResCout, 1);
        check("ff_done_go", AddGo,   0);
        tick();
        check("ff_accepted", ResValid, 0);

        // Fill FIFO while the FSM is held in DONE
        ResReady = 1'b0;
        push(4'h1, 4'h2);
        expect_res("p0", 4'h3, 1'b0);
        push(4'h2, 4'h3);
        push(4'h4, 4'h5);
        push(4'h9, 4'h8);
        push(4'hC, 4'h7);
        check("full_count",   Count,   4);
        check("full_inready", InReady, 0);
        push(4'hF, 4'h1);
        check("drop_count", Count, 4);

        // Result held under back-pressure
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_valid", ResValid, 1);
            check("hold_sum",   ResSum,   4'h3);
            check("hold_cout",  ResCout,  0);
            check("hold_go",    AddGo,    0);
            check("hold_count", Count,    4);
        end

        // Drain in push order
        ResReady = 1'b1;
        tick();
        expect_res("q0", 4'h5, 1'b0);
        expect_res("q1", 4'h9, 1'b0);
        expect_res("q2", 4'h1, 1'b1);
        expect_res("q3", 4'h3, 1'b1);
        tick();
        check("drain_count", Count,    0);
        check("drain_valid", ResValid, 0);

        // Push in the same cycle as an IDLE pop with Count=2
        ResReady = 1'b0;
        push(4'h5, 4'h5);
        expect_res("x", 4'hA, 1'b0);
        push(4'h6, 4'h1);
        push(4'h8, 4'h8);
        check("pp_count_pre", Count, 2);
        ResReady = 1'b1;
        tick();
        check("pp_idle_valid", ResValid, 0);
        check("pp_idle_count", Count,    2);
        push(4'hF, 4'h2);
        check("pp_count", Count, 2);
        check("pp_adda",  AddA,  4'h6);
        check("pp_addb",  AddB,  4'h1);
        expect_res("y", 4'h7, 1'b0);
        expect_res("z", 4'h0, 1'b1);
        expect_res("w", 4'h1, 1'b1);
        tick();
        check("pp_drain_count", Count, 0);

        // Reset during RUN with cnt=2
        push(4'h7, 4'h7);
        push(4'h2, 4'h2);
        tick();
        tick();
        tick();
        check("run_go",    AddGo, 1);
        check("run_count", Count, 1);
        check("run_adda",  AddA,  4'h7);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("abort_go",      AddGo,    0);
        check("abort_count",   Count,    0);
        check("abort_valid",   ResValid, 0);
        check("abort_inready", InReady,  1);
        check("abort_adda",    AddA,     0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            seen = seen | ResValid;
        end
        check("abort_no_result", seen, 0);

        // Wrong adder result: 3 + 4 forced to 0
        bad = 1'b1;
        push(4'h3, 4'h4);
        expect_res("bad", 4'h0, 1'b0);
        check("bad_mismatch", Mismatch, MISMATCH_ON_BAD);
        bad = 1'b0;
        tick();
        push(4'h1, 4'h1);
        expect_res("good", 4'h2, 1'b0);
        check("sticky_mismatch", Mismatch, MISMATCH_ON_BAD);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("clear_mismatch", Mismatch, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
